mc_ctrl: RTL and testbench

//  Multi-cycle main control FSM for the MIPS core. Sequences each instruction through

---
 rtl/mc_ctrl_pkg.sv | 96 +++++++++
 rtl/mc_ctrl_if.sv | 39 +++
 rtl/mc_ctrl_decode.sv | 54 +++++
 rtl/mc_ctrl.sv | 150 +++++++++++++++
 tb/tb_mc_ctrl.sv | 279 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/mc_ctrl_pkg.sv
// Shared definitions for the multi-cycle MIPS main control FSM:
// state encoding, instruction classes, opcode/funct constants,
// ALU operation codes and datapath select codes.
package mc_ctrl_pkg;

    localparam int unsigned STATE_W  = 4;
    localparam int unsigned OP_W     = 6;
    localparam int unsigned FUNCT_W  = 6;
    localparam int unsigned ALU_OP_W = 4;
    localparam int unsigned SEL_W    = 2;

    typedef enum logic [STATE_W-1:0] {
        ST_FETCH    = 4'd0,
        ST_DECODE   = 4'd1,
        ST_MEM_ADDR = 4'd2,
        ST_MEM_RD   = 4'd3,
        ST_MEM_WB   = 4'd4,
        ST_MEM_WR   = 4'd5,
        ST_R_EXEC   = 4'd6,
        ST_R_WB     = 4'd7,
        ST_I_EXEC   = 4'd8,
        ST_I_WB     = 4'd9,
        ST_BRANCH   = 4'd10,
        ST_JUMP     = 4'd11,
        ST_ILLEGAL  = 4'd12
    } state_t;

    typedef enum logic [2:0] {
        CLS_R   = 3'd0,
        CLS_LW  = 3'd1,
        CLS_SW  = 3'd2,
        CLS_BEQ = 3'd3,
        CLS_BNE = 3'd4,
        CLS_J   = 3'd5,
        CLS_I   = 3'd6,
        CLS_ILL = 3'd7
    } instr_cls_t;

    // Opcodes (IR[31:26])
    localparam logic [OP_W-1:0] OP_RTYPE = 6'h00;
    localparam logic [OP_W-1:0] OP_J     = 6'h02;
    localparam logic [OP_W-1:0] OP_BEQ   = 6'h04;
    localparam logic [OP_W-1:0] OP_BNE   = 6'h05;
    localparam logic [OP_W-1:0] OP_ADDI  = 6'h08;
    localparam logic [OP_W-1:0] OP_ADDIU = 6'h09;
    localparam logic [OP_W-1:0] OP_SLTI  = 6'h0A;
    localparam logic [OP_W-1:0] OP_SLTIU = 6'h0B;
    localparam logic [OP_W-1:0] OP_ANDI  = 6'h0C;
    localparam logic [OP_W-1:0] OP_ORI   = 6'h0D;
    localparam logic [OP_W-1:0] OP_XORI  = 6'h0E;
    localparam logic [OP_W-1:0] OP_LUI   = 6'h0F;
    localparam logic [OP_W-1:0] OP_LW    = 6'h23;
    localparam logic [OP_W-1:0] OP_SW    = 6'h2B;

    // R-type function codes (IR[5:0])
    localparam logic [FUNCT_W-1:0] FN_SLL  = 6'h00;
    localparam logic [FUNCT_W-1:0] FN_SRL  = 6'h02;
    localparam logic [FUNCT_W-1:0] FN_SRA  = 6'h03;
    localparam logic [FUNCT_W-1:0] FN_ADD  = 6'h20;
    localparam logic [FUNCT_W-1:0] FN_ADDU = 6'h21;
    localparam logic [FUNCT_W-1:0] FN_SUB  = 6'h22;
    localparam logic [FUNCT_W-1:0] FN_SUBU = 6'h23;
    localparam logic [FUNCT_W-1:0] FN_AND  = 6'h24;
    localparam logic [FUNCT_W-1:0] FN_OR   = 6'h25;
    localparam logic [FUNCT_W-1:0] FN_XOR  = 6'h26;
    localparam logic [FUNCT_W-1:0] FN_NOR  = 6'h27;
    localparam logic [FUNCT_W-1:0] FN_SLT  = 6'h2A;
    localparam logic [FUNCT_W-1:0] FN_SLTU = 6'h2B;

    // ALU operation codes
    localparam logic [ALU_OP_W-1:0] ALU_ADD  = 4'd0;
    localparam logic [ALU_OP_W-1:0] ALU_SUB  = 4'd1;
    localparam logic [ALU_OP_W-1:0] ALU_AND  = 4'd2;
    localparam logic [ALU_OP_W-1:0] ALU_OR   = 4'd3;
    localparam logic [ALU_OP_W-1:0] ALU_XOR  = 4'd4;
    localparam logic [ALU_OP_W-1:0] ALU_NOR  = 4'd5;
    localparam logic [ALU_OP_W-1:0] ALU_SLT  = 4'd6;
    localparam logic [ALU_OP_W-1:0] ALU_SLTU = 4'd7;
    localparam logic [ALU_OP_W-1:0] ALU_LUI  = 4'd8;
    localparam logic [ALU_OP_W-1:0] ALU_SLL  = 4'd9;
    localparam logic [ALU_OP_W-1:0] ALU_SRL  = 4'd10;
    localparam logic [ALU_OP_W-1:0] ALU_SRA  = 4'd11;

    // pc_source codes
    localparam logic [SEL_W-1:0] PC_SRC_ALU    = 2'd0;
    localparam logic [SEL_W-1:0] PC_SRC_ALUOUT = 2'd1;
    localparam logic [SEL_W-1:0] PC_SRC_JUMP   = 2'd2;
    localparam logic [SEL_W-1:0] EXC_VEC_SEL   = 2'd3;

    // alu_src_b codes
    localparam logic [SEL_W-1:0] SRCB_RT     = 2'd0;
    localparam logic [SEL_W-1:0] SRCB_FOUR   = 2'd1;
    localparam logic [SEL_W-1:0] SRCB_IMM    = 2'd2;
    localparam logic [SEL_W-1:0] SRCB_IMM_SH = 2'd3;

endpackage

// File: rtl/mc_ctrl_if.sv
// Control bus between the main control FSM and the shared datapath.
// master: the controller (drives selects/strobes, reads IR fields, zero, mem_ready).
// slave : the datapath/memory side.
interface mc_ctrl_if;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       zero;
    logic       mem_ready;
    logic       mem_req;
    logic       mem_we;
    logic       iord;
    logic       ir_write;
    logic       pc_write;
    logic       pc_write_cond;
    logic [1:0] pc_source;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [3:0] alu_op;
    logic       sign_ext;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       exc_illegal;
    logic [3:0] state_o;

    modport master (
        input  opcode, funct, zero, mem_ready,
        output mem_req, mem_we, iord, ir_write, pc_write, pc_write_cond, pc_source,
               alu_src_a, alu_src_b, alu_op, sign_ext, reg_write, reg_dst,
               mem_to_reg, exc_illegal, state_o
    );

    modport slave (
        output opcode, funct, zero, mem_ready,
        input  mem_req, mem_we, iord, ir_write, pc_write, pc_write_cond, pc_source,
               alu_src_a, alu_src_b, alu_op, sign_ext, reg_write, reg_dst,
               mem_to_reg, exc_illegal, state_o
    );
endinterface

// File: rtl/mc_ctrl_decode.sv
// Combinational instruction decoder: opcode/funct -> class, ALU op, extender mode.
// Ports: i_opcode, i_funct (IR fields); o_cls_c, o_alu_op_c, o_sign_ext_c.
module mc_ctrl_decode
    import mc_ctrl_pkg::*;
(
    input  logic [OP_W-1:0]     i_opcode,
    input  logic [FUNCT_W-1:0]  i_funct,
    output instr_cls_t          o_cls_c,
    output logic [ALU_OP_W-1:0] o_alu_op_c,
    output logic                o_sign_ext_c
);

    // Instruction class plus the ALU op / extender mode used in the EXEC states
    always_comb begin
        o_cls_c      = CLS_ILL;
        o_alu_op_c   = ALU_ADD;
        o_sign_ext_c = 1'b1;
        case (i_opcode)
            OP_RTYPE: begin
                o_cls_c      = CLS_R;
                o_sign_ext_c = 1'b0;
                case (i_funct)
                    FN_SLL:          o_alu_op_c = ALU_SLL;
                    FN_SRL:          o_alu_op_c = ALU_SRL;
                    FN_SRA:          o_alu_op_c = ALU_SRA;
                    FN_ADD, FN_ADDU: o_alu_op_c = ALU_ADD;
                    FN_SUB, FN_SUBU: o_alu_op_c = ALU_SUB;
                    FN_AND:          o_alu_op_c = ALU_AND;
                    FN_OR:           o_alu_op_c = ALU_OR;
                    FN_XOR:          o_alu_op_c = ALU_XOR;
                    FN_NOR:          o_alu_op_c = ALU_NOR;
                    FN_SLT:          o_alu_op_c = ALU_SLT;
                    FN_SLTU:         o_alu_op_c = ALU_SLTU;
                    default:         o_alu_op_c = ALU_ADD;
                endcase
            end
            OP_LW:    o_cls_c = CLS_LW;
            OP_SW:    o_cls_c = CLS_SW;
            OP_BEQ:   o_cls_c = CLS_BEQ;
            OP_BNE:   o_cls_c = CLS_BNE;
            OP_J:     o_cls_c = CLS_J;
            OP_ADDI, OP_ADDIU: o_cls_c = CLS_I;
            OP_SLTI:  begin o_cls_c = CLS_I; o_alu_op_c = ALU_SLT;  end
            OP_SLTIU: begin o_cls_c = CLS_I; o_alu_op_c = ALU_SLTU; end
            // Logical immediates and lui zero-extend
            OP_ANDI:  begin o_cls_c = CLS_I; o_alu_op_c = ALU_AND; o_sign_ext_c = 1'b0; end
            OP_ORI:   begin o_cls_c = CLS_I; o_alu_op_c = ALU_OR;  o_sign_ext_c = 1'b0; end
            OP_XORI:  begin o_cls_c = CLS_I; o_alu_op_c = ALU_XOR; o_sign_ext_c = 1'b0; end
            OP_LUI:   begin o_cls_c = CLS_I; o_alu_op_c = ALU_LUI; o_sign_ext_c = 1'b0; end
            default:  o_cls_c = CLS_ILL;
        endcase
    end

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS main control FSM. Sequences fetch/decode/execute/memory/writeback
// and drives all datapath selects; stalls on a single-outstanding memory handshake.
// Ports: clk, rst (synchronous, active-high), bus (mc_ctrl_if.master: IR fields,
//        zero, mem_ready in; memory/PC/ALU/regfile controls and state_o out).
// Build option: MC_CTRL_EXC_EN enables the illegal-instruction exception in ILLEGAL;
//        without it ILLEGAL is a one-cycle NOP and exc_illegal stays 0.
module mc_ctrl
    import mc_ctrl_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    mc_ctrl_if.master    bus
);

    state_t                r_state;
    state_t                w_next_state;
    instr_cls_t            w_cls;
    logic [ALU_OP_W-1:0]   w_alu_op;
    logic                  w_sign_ext;

    mc_ctrl_decode u_decode (
        .i_opcode     (bus.opcode),
        .i_funct      (bus.funct),
        .o_cls_c      (w_cls),
        .o_alu_op_c   (w_alu_op),
        .o_sign_ext_c (w_sign_ext)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_FETCH;
        else     r_state <= w_next_state;
    end

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_FETCH:    if (bus.mem_ready) w_next_state = ST_DECODE;
            ST_DECODE: begin
                case (w_cls)
                    CLS_R:           w_next_state = ST_R_EXEC;
                    CLS_LW, CLS_SW:  w_next_state = ST_MEM_ADDR;
                    CLS_BEQ, CLS_BNE: w_next_state = ST_BRANCH;
                    CLS_J:           w_next_state = ST_JUMP;
                    CLS_I:           w_next_state = ST_I_EXEC;
                    default:         w_next_state = ST_ILLEGAL;
                endcase
            end
            ST_MEM_ADDR: w_next_state = (w_cls == CLS_SW) ? ST_MEM_WR : ST_MEM_RD;
            ST_MEM_RD:   if (bus.mem_ready) w_next_state = ST_MEM_WB;
            ST_MEM_WR:   if (bus.mem_ready) w_next_state = ST_FETCH;
            ST_R_EXEC:   w_next_state = ST_R_WB;
            ST_I_EXEC:   w_next_state = ST_I_WB;
            default:     w_next_state = ST_FETCH;
        endcase
    end

    assign bus.state_o = r_state;

    // Output decode; everything is forced quiet while rst is asserted
    always_comb begin
        bus.mem_req       = 1'b0;
        bus.mem_we        = 1'b0;
        bus.iord          = 1'b0;
        bus.ir_write      = 1'b0;
        bus.pc_write      = 1'b0;
        bus.pc_write_cond = 1'b0;
        bus.pc_source     = PC_SRC_ALU;
        bus.alu_src_a     = 1'b0;
        bus.alu_src_b     = SRCB_RT;
        bus.alu_op        = ALU_ADD;
        bus.sign_ext      = 1'b0;
        bus.reg_write     = 1'b0;
        bus.reg_dst       = 1'b0;
        bus.mem_to_reg    = 1'b0;
        bus.exc_illegal   = 1'b0;
        if (!rst) begin
            case (r_state)
                ST_FETCH: begin
                    // PC+4 computed during fetch; IR and PC load when memory returns
                    bus.mem_req   = 1'b1;
                    bus.alu_src_b = SRCB_FOUR;
                    bus.ir_write  = bus.mem_ready;
                    bus.pc_write  = bus.mem_ready;
                end
                ST_DECODE: begin
                    // Speculative branch target PC + (imm << 2)
                    bus.alu_src_b = SRCB_IMM_SH;
                    bus.sign_ext  = 1'b1;
                end
                ST_MEM_ADDR: begin
                    bus.alu_src_a = 1'b1;
                    bus.alu_src_b = SRCB_IMM;
                    bus.sign_ext  = 1'b1;
                end
                ST_MEM_RD: begin
                    bus.mem_req = 1'b1;
                    bus.iord    = 1'b1;
                end
                ST_MEM_WB: begin
                    bus.reg_write  = 1'b1;
                    bus.mem_to_reg = 1'b1;
                end
                ST_MEM_WR: begin
                    bus.mem_req = 1'b1;
                    bus.iord    = 1'b1;
                    bus.mem_we  = 1'b1;
                end
                ST_R_EXEC: begin
                    bus.alu_src_a = 1'b1;
                    bus.alu_op    = w_alu_op;
                end
                ST_R_WB: begin
                    bus.reg_write = 1'b1;
                    bus.reg_dst   = 1'b1;
                end
                ST_I_EXEC: begin
                    bus.alu_src_a = 1'b1;
                    bus.alu_src_b = SRCB_IMM;
                    bus.alu_op    = w_alu_op;
                    bus.sign_ext  = w_sign_ext;
                end
                ST_I_WB: bus.reg_write = 1'b1;
                ST_BRANCH: begin
                    // Taken when equal for beq, not equal for bne
                    bus.alu_src_a     = 1'b1;
                    bus.alu_op        = ALU_SUB;
                    bus.pc_source     = PC_SRC_ALUOUT;
                    bus.pc_write_cond = bus.zero ^ (w_cls == CLS_BNE);
                end
                ST_JUMP: begin
                    bus.pc_write  = 1'b1;
                    bus.pc_source = PC_SRC_JUMP;
                end
`ifdef MC_CTRL_EXC_EN
                ST_ILLEGAL: begin
                    bus.exc_illegal = 1'b1;
                    bus.pc_write    = 1'b1;
                    bus.pc_source   = EXC_VEC_SEL;
                end
`else
                ST_ILLEGAL: bus.exc_illegal = 1'b0;
`endif
                default: bus.mem_req = 1'b0;
            endcase
        end
    end

endmodule

// File: tb/tb_mc_ctrl.sv
// Scoreboard bench for mc_ctrl: stimulus pushes hand-derived per-cycle expected
// control vectors; a negedge monitor pops and compares against the DUT outputs.
module tb_mc_ctrl;
    import mc_ctrl_pkg::*;

    localparam int unsigned TIMEOUT_CYC = 2000;

    typedef struct packed {
        logic [3:0] st;
        logic       mem_req;
        logic       mem_we;
        logic       iord;
        logic       ir_write;
        logic       pc_write;
        logic       pc_wc;
        logic [1:0] pc_src;
        logic       src_a;
        logic [1:0] src_b;
        logic [3:0] alu_op;
        logic       sext;
        logic       reg_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       exc;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mc_ctrl_if bus();
    mc_ctrl dut (.clk(clk), .rst(rst), .bus(bus));

    exp_t  q[$];
    string nq[$];
    int    n_tests = 0;
    int    n_fail  = 0;
    exp_t  m_exp;
    exp_t  m_act;
    string m_name;
    logic  done = 1'b0;

    function automatic exp_t sample();
        exp_t a;
        a.st         = bus.state_o;
        a.mem_req    = bus.mem_req;
        a.mem_we     = bus.mem_we;
        a.iord       = bus.iord;
        a.ir_write   = bus.ir_write;
        a.pc_write   = bus.pc_write;
        a.pc_wc      = bus.pc_write_cond;
        a.pc_src     = bus.pc_source;
        a.src_a      = bus.alu_src_a;
        a.src_b      = bus.alu_src_b;
        a.alu_op     = bus.alu_op;
        a.sext       = bus.sign_ext;
        a.reg_write  = bus.reg_write;
        a.reg_dst    = bus.reg_dst;
        a.mem_to_reg = bus.mem_to_reg;
        a.exc        = bus.exc_illegal;
        return a;
    endfunction

    // Monitor: compare every cycle for which an expectation is queued
    always @(negedge clk) begin
        if (q.size() != 0) begin
            m_exp  = q.pop_front();
            m_name = nq.pop_front();
            m_act  = sample();
            n_tests++;
            if (m_act !== m_exp) begin
                n_fail++;
                $display("FAIL %s: got %h want %h", m_name, m_act, m_exp);
            end
        end
    end

    // Watchdog: stimulus must complete within the cycle budget
    initial begin
        for (int unsigned i = 0; i < TIMEOUT_CYC; i++) begin
            @(posedge clk);
            if (done) break;
        end
        n_tests++;
        if (!done) begin
            n_fail++;
            $display("FAIL timeout: stimulus did not complete in %0d cycles", TIMEOUT_CYC);
            $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
            $finish;
        end
    end

    function automatic exp_t ex(input state_t st);
        exp_t e;
        e    = '0;
        e.st = st;
        return e;
    endfunction

    task automatic step(input string nm, input exp_t e);
        q.push_back(e);
        nq.push_back(nm);
        @(posedge clk);
        #1;
    endtask

    task automatic do_fetch(input int nwait, input logic [5:0] op, input logic [5:0] fn);
        exp_t e;
        bus.opcode = op;
        bus.funct  = fn;
        e = ex(ST_FETCH);
        e.mem_req = 1'b1;
        e.src_b   = 2'd1;
        for (int i = 0; i < nwait; i++) begin
            bus.mem_ready = 1'b0;
            step("fetch_wait", e);
        end
        bus.mem_ready = 1'b1;
        e.ir_write = 1'b1;
        e.pc_write = 1'b1;
        step("fetch", e);
    endtask

    task automatic do_decode();
        exp_t e;
        e = ex(ST_DECODE);
        e.src_b = 2'd3;
        e.sext  = 1'b1;
        step("decode", e);
    endtask

    task automatic do_itype(input string nm, input logic [5:0] op,
                            input logic [3:0] aop, input logic sx);
        exp_t e;
        do_fetch(0, op, 6'h00);
        do_decode();
        e = ex(ST_I_EXEC);
        e.src_a  = 1'b1;
        e.src_b  = 2'd2;
        e.alu_op = aop;
        e.sext   = sx;
        step(nm, e);
        e = ex(ST_I_WB);
        e.reg_write = 1'b1;
        step("i_wb", e);
    endtask

    task automatic do_branch(input string nm, input logic [5:0] op, input logic z,
                             input logic taken);
        exp_t e;
        do_fetch(0, op, 6'h00);
        do_decode();
        bus.zero = z;
        e = ex(ST_BRANCH);
        e.src_a  = 1'b1;
        e.alu_op = ALU_SUB;
        e.pc_src = 2'd1;
        e.pc_wc  = taken;
        step(nm, e);
        bus.zero = 1'b0;
    endtask

    initial begin
        exp_t e;
        rst           = 1'b1;
        bus.mem_ready = 1'b0;
        bus.opcode    = 6'h00;
        bus.funct     = 6'h00;
        bus.zero      = 1'b0;

        // Reset: two cycles, outputs quiet, state lands in FETCH
        @(posedge clk);
        #1;
        step("reset", ex(ST_FETCH));
        rst = 1'b0;

        // Reset-state check: FETCH with mem_req raised, no strobes
        #1;
        n_tests++;
        if (bus.state_o !== ST_FETCH || bus.mem_req !== 1'b1 ||
            bus.ir_write !== 1'b0 || bus.pc_write !== 1'b0) begin
            n_fail++;
            $display("FAIL post_reset: state=%h mem_req=%b ir_write=%b pc_write=%b",
                     bus.state_o, bus.mem_req, bus.ir_write, bus.pc_write);
        end

        // Fetch with memory stall, then addi / logical immediates
        do_fetch(2, 6'h08, 6'h00);
        do_decode();
        e = ex(ST_I_EXEC);
        e.src_a = 1'b1; e.src_b = 2'd2; e.alu_op = ALU_ADD; e.sext = 1'b1;
        step("addi_exec", e);
        e = ex(ST_I_WB);
        e.reg_write = 1'b1;
        step("addi_wb", e);
        do_itype("ori_exec",  6'h0D, ALU_OR,  1'b0);
        do_itype("andi_exec", 6'h0C, ALU_AND, 1'b0);
        do_itype("xori_exec", 6'h0E, ALU_XOR, 1'b0);
        do_itype("slti_exec", 6'h0A, ALU_SLT, 1'b1);

        // lw with three memory wait cycles in MEM_RD
        do_fetch(0, 6'h23, 6'h00);
        do_decode();
        e = ex(ST_MEM_ADDR);
        e.src_a = 1'b1; e.src_b = 2'd2; e.sext = 1'b1;
        step("lw_addr", e);
        e = ex(ST_MEM_RD);
        e.mem_req = 1'b1; e.iord = 1'b1;
        bus.mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) step("lw_wait", e);
        bus.mem_ready = 1'b1;
        step("lw_rd", e);
        e = ex(ST_MEM_WB);
        e.reg_write = 1'b1; e.mem_to_reg = 1'b1;
        step("lw_wb", e);

        // sw with one wait cycle
        do_fetch(0, 6'h2B, 6'h00);
        do_decode();
        e = ex(ST_MEM_ADDR);
        e.src_a = 1'b1; e.src_b = 2'd2; e.sext = 1'b1;
        step("sw_addr", e);
        e = ex(ST_MEM_WR);
        e.mem_req = 1'b1; e.iord = 1'b1; e.mem_we = 1'b1;
        bus.mem_ready = 1'b0;
        step("sw_wait", e);
        bus.mem_ready = 1'b1;
        step("sw_wr", e);

        // R-type sub
        do_fetch(0, 6'h00, 6'h22);
        do_decode();
        e = ex(ST_R_EXEC);
        e.src_a = 1'b1; e.alu_op = ALU_SUB;
        step("r_exec", e);
        e = ex(ST_R_WB);
        e.reg_write = 1'b1; e.reg_dst = 1'b1;
        step("r_wb", e);

        // Branches
        do_branch("beq_taken",  6'h04, 1'b1, 1'b1);
        do_branch("beq_not",    6'h04, 1'b0, 1'b0);
        do_branch("bne_taken",  6'h05, 1'b0, 1'b1);

        // Jump
        do_fetch(0, 6'h02, 6'h00);
        do_decode();
        e = ex(ST_JUMP);
        e.pc_write = 1'b1; e.pc_src = 2'd2;
        step("jump", e);

        // Illegal opcode
        do_fetch(0, 6'h3F, 6'h00);
        do_decode();
        e = ex(ST_ILLEGAL);
`ifdef MC_CTRL_EXC_EN
        e.exc = 1'b1; e.pc_write = 1'b1; e.pc_src = 2'd3;
`endif
        step("illegal", e);

        // Reset mid-instruction aborts lw to FETCH
        do_fetch(0, 6'h23, 6'h00);
        do_decode();
        e = ex(ST_MEM_ADDR);
        e.src_a = 1'b1; e.src_b = 2'd2; e.sext = 1'b1;
        step("lw2_addr", e);
        bus.mem_ready = 1'b0;
        rst = 1'b1;
        step("mid_reset", ex(ST_MEM_RD));
        rst = 1'b0;
        do_fetch(1, 6'h00, 6'h20);

        @(negedge clk);
        done = 1'b1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
